// File: rtl/syn_fft_sample_buf.sv
// Ping-pong multi-channel sample capture buffer feeding the FFT engine.
// One bank fills from the PCM path while the other replays channel by channel in natural or bit-reversed order.
module syn_fft_sample_buf #(
   parameter int DATA_W      = 32,
   parameter int NUM_SAMPLES = 128,
   parameter int NUM_CH      = 2,
   localparam int IDX_W      = $clog2(NUM_SAMPLES),
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_ir,
   input  logic              rst_il,
   input  logic [DATA_W-1:0] pcm_data_id,
   input  logic [CH_W-1:0]   pcm_chan_id,
   input  logic              pcm_valid_ih,
   output logic              pcm_ready_oh,
   input  logic              bitrev_en_ih,
   output logic [DATA_W-1:0] fft_data_od,
   output logic [CH_W-1:0]   fft_chan_od,
   output logic [IDX_W-1:0]  fft_idx_od,
   output logic              fft_sof_oh,
   output logic              fft_eof_oh,
   output logic              fft_valid_oh,
   input  logic              fft_ready_ih,
   output logic              ovrflw_oh
);

   localparam int AW    = 1 + CH_W + IDX_W;
   localparam int DEPTH = 2 ** AW;
   localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(NUM_SAMPLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
   localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

   typedef struct packed {
      logic [CH_W-1:0]  chan;
      logic [IDX_W-1:0] idx;
      logic             sof;
      logic             eof;
   } meta_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      meta_t             meta;
   } beat_t;

   function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
      logic [IDX_W-1:0] r;
      for (int i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
      return r;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_rdata_q;

   logic             rdy_en_q, rdy_en_d;
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IDX_W:0]   wr_cnt_q [NUM_CH];
   logic [IDX_W:0]   wr_cnt_d [NUM_CH];
   logic             ovrflw_q, ovrflw_d;
   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             ram_v_q, ram_v_d;
   meta_t            ram_meta_q, ram_meta_d;
   logic             out_v_q, out_v_d;
   beat_t            out_q, out_d;
   logic             skid_v_q, skid_v_d;
   beat_t            skid_q, skid_d;

   logic             accept, chan_ok, wr_en, bank_done, rd_issue, release_bank, pop, space;
   logic [IDX_W:0]   sel_cnt;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic [IDX_W-1:0] rd_idx_rep;
   logic [2:0]       occ;
   beat_t            in_beat;

   assign pcm_ready_oh = rst_il && rdy_en_q && !full_q[wr_bank_q];

   // Write side: per-channel fill counters; the bank closes on the write that fills the last channel.
   always_comb begin
      sel_cnt = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (pcm_chan_id == CH_W'(c)) sel_cnt = wr_cnt_q[c];
      chan_ok   = ({1'b0, pcm_chan_id} < NUM_CH_V);
      accept    = pcm_valid_ih && pcm_ready_oh;
      wr_en     = accept && chan_ok && (sel_cnt != CNT_FULL);
      ovrflw_d  = accept && !wr_en;
      wr_addr   = {wr_bank_q, pcm_chan_id, sel_cnt[IDX_W-1:0]};
      rdy_en_d  = 1'b1;
      wr_cnt_d  = wr_cnt_q;
      bank_done = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_en && (pcm_chan_id == CH_W'(c))) wr_cnt_d[c] = wr_cnt_q[c] + 1'b1;
         if (wr_cnt_d[c] != CNT_FULL) bank_done = 1'b0;
      end
      wr_bank_d = wr_bank_q;
      if (bank_done) begin
         for (int c = 0; c < NUM_CH; c++) wr_cnt_d[c] = '0;
         wr_bank_d = ~wr_bank_q;
      end
   end

   // Reads are issued only when the RAM stage plus output/skid registers can absorb them.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      rd_ch_d      = rd_ch_q;
      rd_idx_d     = rd_idx_q;
      rd_bank_d    = rd_bank_q;
      rd_issue     = 1'b0;
      release_bank = 1'b0;
      pop          = out_v_q && fft_ready_ih;
      occ          = 3'(out_v_q) + 3'(skid_v_q) + 3'(ram_v_q);
      space        = occ <= (pop ? 3'd2 : 3'd1);
      rd_idx_rep   = mode_q ? bit_rev(rd_idx_q) : rd_idx_q;
      rd_addr      = {rd_bank_q, rd_ch_q, rd_idx_rep};
      case (state_q)
         ST_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = ST_READ;
               mode_d   = bitrev_en_ih;
               rd_ch_d  = '0;
               rd_idx_d = '0;
            end
         end
         ST_READ: begin
            if (space) begin
               rd_issue = 1'b1;
               if (rd_idx_q == IDX_LAST) begin
                  rd_idx_d = '0;
                  if (rd_ch_q == CH_LAST) state_d = ST_DRAIN;
                  else rd_ch_d = rd_ch_q + 1'b1;
               end else begin
                  rd_idx_d = rd_idx_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!ram_v_q && !skid_v_q && (!out_v_q || pop)) begin
               release_bank = 1'b1;
               rd_bank_d    = ~rd_bank_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      full_d = full_q;
      if (bank_done) full_d[wr_bank_q] = 1'b1;
      if (release_bank) full_d[rd_bank_q] = 1'b0;

      ram_v_d    = rd_issue;
      ram_meta_d = ram_meta_q;
      if (rd_issue) begin
         ram_meta_d.chan = rd_ch_q;
         ram_meta_d.idx  = rd_idx_rep;
         ram_meta_d.sof  = (rd_idx_q == '0);
         ram_meta_d.eof  = (rd_idx_q == IDX_LAST);
      end

      in_beat  = {ram_rdata_q, ram_meta_q};
      out_v_d  = out_v_q;
      out_d    = out_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      if (!out_v_q || pop) begin
         if (skid_v_q) begin
            out_v_d  = 1'b1;
            out_d    = skid_q;
            skid_v_d = ram_v_q;
            if (ram_v_q) skid_d = in_beat;
         end else begin
            out_v_d = ram_v_q;
            if (ram_v_q) out_d = in_beat;
         end
      end else if (ram_v_q) begin
         skid_v_d = 1'b1;
         skid_d   = in_beat;
      end
   end

   always_ff @(posedge clk_ir) begin
      if (wr_en) mem[wr_addr] <= pcm_data_id;
      if (rd_issue) ram_rdata_q <= mem[rd_addr];
   end

   always_ff @(posedge clk_ir) begin
      if (!rst_il) begin
         rdy_en_q   <= 1'b0;
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_cnt_q   <= '{default: '0};
         ovrflw_q   <= 1'b0;
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         rd_ch_q    <= '0;
         rd_idx_q   <= '0;
         ram_v_q    <= 1'b0;
         ram_meta_q <= '0;
         out_v_q    <= 1'b0;
         out_q      <= '0;
         skid_v_q   <= 1'b0;
         skid_q     <= '0;
      end else begin
         rdy_en_q   <= rdy_en_d;
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         ovrflw_q   <= ovrflw_d;
         state_q    <= state_d;
         mode_q     <= mode_d;
         rd_ch_q    <= rd_ch_d;
         rd_idx_q   <= rd_idx_d;
         ram_v_q    <= ram_v_d;
         ram_meta_q <= ram_meta_d;
         out_v_q    <= out_v_d;
         out_q      <= out_d;
         skid_v_q   <= skid_v_d;
         skid_q     <= skid_d;
      end
   end

   assign fft_data_od  = out_q.data;
   assign fft_chan_od  = out_q.meta.chan;
   assign fft_idx_od   = out_q.meta.idx;
   assign fft_sof_oh   = out_q.meta.sof;
   assign fft_eof_oh   = out_q.meta.eof;
   assign fft_valid_oh = out_v_q;
   assign ovrflw_oh    = ovrflw_q;

endmodule
